// File: rtl/agu_rdstream_if.sv
// Read-stream engine bundle: job control, AGU handshake, RAM read port and output stream.
// master = the engine, slave = its surroundings (AGU, RAM, consumer, job controller).
interface agu_rdstream_if #(
  parameter int BWADDR  = 21,
  parameter int BWDATA  = 32,
  parameter int BWCOUNT = 16
);
  logic               start;
  logic [BWADDR-1:0]  base_addr;
  logic [BWCOUNT-1:0] count;
  logic               busy;
  logic               done;
  logic               agu_clr;
  logic               agu_step;
  logic [BWADDR-1:0]  agu_addr;
  logic               rd_en;
  logic [BWADDR-1:0]  rd_addr;
  logic [BWDATA-1:0]  rd_data;
  logic [BWDATA-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  start, base_addr, count, agu_addr, rd_data, out_ready,
    output busy, done, agu_clr, agu_step, rd_en, rd_addr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, count, agu_addr, rd_data, out_ready,
    input  busy, done, agu_clr, agu_step, rd_en, rd_addr, out_data, out_valid
  );
endinterface

// File: rtl/agu_rdstream.sv
// Job sequencer issuing base+AGU-offset reads to a fixed-latency RAM; words land in a FIFO after RDLAT edges.
// Backpressure: a read is issued only while FIFO fill plus in-flight reads leaves a free slot.
module agu_rdstream #(
  parameter int BWADDR    = 21,
  parameter int BWDATA    = 32,
  parameter int BWCOUNT   = 16,
  parameter int RDLAT     = 2,
  parameter int FIFODEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  agu_rdstream_if.master bus
);
  localparam int AW = $clog2(FIFODEPTH);
  localparam int CW = $clog2(FIFODEPTH + 1);
  localparam int SW = $clog2(FIFODEPTH + RDLAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN} state_t;

  state_t             state;
  logic [BWADDR-1:0]  base_q;
  logic [BWCOUNT-1:0] remaining;
  logic               busy_q;
  logic               done_q;
  logic               clr_q;

  logic [RDLAT-1:0]   vld_sr;
  logic [SW-1:0]      inflight;

  logic [BWDATA-1:0]  mem [FIFODEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;

  logic issue;
  logic push;
  logic pop;
  logic fifo_nonempty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) begin
      inflight = inflight + SW'(vld_sr[i]);
    end
  end

  // Credit uses pre-edge fill and in-flight counts; a pop this cycle frees credit next cycle.
  assign issue = (state == S_RUN) && (remaining != '0) &&
                 ((SW'(fifo_cnt) + inflight) < SW'(FIFODEPTH));
  assign push          = vld_sr[RDLAT-1];
  assign fifo_nonempty = (fifo_cnt != '0);
  assign pop           = fifo_nonempty && bus.out_ready;

  assign bus.rd_en     = issue;
  assign bus.agu_step  = issue;
  assign bus.rd_addr   = issue ? (base_q + bus.agu_addr) : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.agu_clr   = clr_q;
  assign bus.out_valid = fifo_nonempty;
  assign bus.out_data  = fifo_nonempty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_q    <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base_q    <= bus.base_addr;
            remaining <= bus.count;
            clr_q     <= 1'b1;
            busy_q    <= 1'b1;
            state     <= S_CLR;
          end
        end
        S_CLR: begin
          clr_q <= 1'b0;
          state <= (remaining != '0) ? S_RUN : S_DRAIN;
        end
        S_RUN: begin
          if (issue) begin
            remaining <= remaining - BWCOUNT'(1);
            if (remaining == BWCOUNT'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Stay here through the done cycle so a start coincident with done is ignored.
          if (done_q) begin
            state <= S_IDLE;
          end else if (inflight == '0 && !fifo_nonempty) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RDLAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rd_data;
    end
  end
endmodule

// File: tb/tb_agu_rdstream.sv
// Self-checking bench: behavioural AGU and RAM, job table plus random jobs, and reset/start corner sequences.
module tb_agu_rdstream;
  localparam int BWADDR    = 21;
  localparam int BWDATA    = 32;
  localparam int BWCOUNT   = 16;
  localparam int RDLAT     = 2;
  localparam int FIFODEPTH = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  agu_rdstream_if #(.BWADDR(BWADDR), .BWDATA(BWDATA), .BWCOUNT(BWCOUNT)) bus ();

  agu_rdstream #(
    .BWADDR(BWADDR), .BWDATA(BWDATA), .BWCOUNT(BWCOUNT),
    .RDLAT(RDLAT), .FIFODEPTH(FIFODEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BWADDR-1:0] base;
    int                cnt;
    int                pat;    // 0: linear offsets, 1: l4=3 j4=1 j3=16
    int                rmode;  // 0: always ready, 1: stall then release, 2: random
    logic [BWADDR-1:0] exp_first;
    logic [BWADDR-1:0] exp_last;
  } vec_t;

  function automatic int agu_off(input int pat, input int k);
    if (pat == 0) return k;
    return (k % 4) + (k / 4) * 16;
  endfunction

  function automatic logic [BWADDR-1:0] model_addr(input logic [BWADDR-1:0] base, input int pat, input int k);
    int s;
    s = int'(base) + agu_off(pat, k);
    return BWADDR'(s & ((1 << BWADDR) - 1));
  endfunction

  function automatic logic [BWDATA-1:0] ram_word(input logic [BWADDR-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // Behavioural AGU: registered offset, cleared by agu_clr, advanced by agu_step.
  int cur_pat;
  int agu_k;
  always @(posedge clk) begin
    if (bus.agu_clr) begin
      agu_k        <= 0;
      bus.agu_addr <= model_addr('0, cur_pat, 0);
    end else if (bus.agu_step) begin
      agu_k        <= agu_k + 1;
      bus.agu_addr <= model_addr('0, cur_pat, agu_k + 1);
    end
  end

  // Fixed-latency RAM; not reset, so words still return across a DUT reset.
  logic [BWDATA-1:0] pipe [RDLAT];
  always @(posedge clk) begin
    pipe[0] <= bus.rd_en ? ram_word(bus.rd_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < RDLAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[RDLAT-1];

  logic [BWADDR-1:0] addr_log [$];
  logic [BWDATA-1:0] data_log [$];
  int                rd_cyc [$];
  int issued, popped, max_out, first_valid_cyc, done_cnt, done_cyc, agu_clr_cyc;
  logic              prev_hold;
  logic [BWDATA-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.rd_en) begin
        addr_log.push_back(bus.rd_addr);
        rd_cyc.push_back(cyc);
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        data_log.push_back(bus.out_data);
        popped++;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.agu_clr) agu_clr_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_hold) chk("hold_stable", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    rd_cyc.delete();
    issued = 0; popped = 0; max_out = 0;
    first_valid_cyc = -1; done_cnt = 0; done_cyc = -1; agu_clr_cyc = -1;
  endtask

  task automatic run_job(input vec_t v);
    int start_cyc;
    int rel;
    int n;
    bit ok;
    clear_logs();
    cur_pat       = v.pat;
    bus.base_addr = v.base;
    bus.count     = BWCOUNT'(v.cnt);
    bus.out_ready = (v.rmode == 0);
    bus.start     = 1'b1;
    start_cyc     = cyc;
    tick();
    bus.start     = 1'b0;
    bus.base_addr = BWADDR'($urandom);
    bus.count     = BWCOUNT'($urandom);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      rel = cyc - start_cyc;
      case (v.rmode)
        0:       bus.out_ready = 1'b1;
        1: begin
          if (rel == 39) begin
            chk("stall_reads", 64'(addr_log.size()), FIFODEPTH);
            chk("stall_valid", bus.out_valid, 1'b1);
          end
          bus.out_ready = (rel >= 40);
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    chk("done_timeout", done_cnt > 0, 1'b1);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("done_once", 64'(done_cnt), 1);
    chk("busy_after", bus.busy, 1'b0);
    chk("clr_cycle", 64'(agu_clr_cyc - start_cyc), 1);
    chk("n_reads", 64'(addr_log.size()), 64'(v.cnt));
    chk("n_words", 64'(data_log.size()), 64'(v.cnt));
    chk("max_outstanding", max_out <= FIFODEPTH, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < v.cnt && k < addr_log.size(); k++)
      if (addr_log[k] !== model_addr(v.base, v.pat, k)) ok = 1'b0;
    chk("addr_seq", ok, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < v.cnt && k < data_log.size(); k++)
      if (data_log[k] !== ram_word(model_addr(v.base, v.pat, k))) ok = 1'b0;
    chk("data_seq", ok, 1'b1);
    if (v.cnt > 0 && addr_log.size() > 0) begin
      chk("first_addr", addr_log[0], v.exp_first);
      chk("last_addr", addr_log[addr_log.size()-1], v.exp_last);
    end
    if (v.cnt == 0) chk("zero_done_cycle", 64'(done_cyc - start_cyc), 3);
    if (v.rmode == 0 && v.cnt > 0 && rd_cyc.size() > 0) begin
      ok = 1'b1;
      for (int k = 0; k < rd_cyc.size(); k++)
        if (rd_cyc[k] != start_cyc + 2 + k) ok = 1'b0;
      chk("rd_back_to_back", ok, 1'b1);
      chk("first_valid_lat", 64'(first_valid_cyc - rd_cyc[0]), RDLAT + 1);
    end
  endtask

  vec_t vt [5];
  vec_t rv;
  logic acc;

  initial begin
    checks = 0; errors = 0; cyc = 0; cur_pat = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.out_ready = 1'b0;
    clear_logs();

    vt[0] = '{base: 21'h000100, cnt: 4,   pat: 0, rmode: 0, exp_first: 21'h000100, exp_last: 21'h000103};
    vt[1] = '{base: 21'h1FFFFE, cnt: 4,   pat: 0, rmode: 0, exp_first: 21'h1FFFFE, exp_last: 21'h000001};
    vt[2] = '{base: 21'h000000, cnt: 20,  pat: 0, rmode: 1, exp_first: 21'h000000, exp_last: 21'h000013};
    vt[3] = '{base: 21'h000abc, cnt: 0,   pat: 0, rmode: 0, exp_first: 21'h000000, exp_last: 21'h000000};
    vt[4] = '{base: 21'h002000, cnt: 100, pat: 1, rmode: 2, exp_first: 21'h002000, exp_last: 21'h002183};

    repeat (3) tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_agu_clr", bus.agu_clr, 1'b0);
    chk("rst_agu_step", bus.agu_step, 1'b0);
    chk("rst_rd_en", bus.rd_en, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_job(vt[i]);

    for (int r = 0; r < 6; r++) begin
      rv.base      = BWADDR'($urandom);
      rv.cnt       = $urandom_range(1, 40);
      rv.pat       = $urandom_range(0, 1);
      rv.rmode     = 2;
      rv.exp_first = model_addr(rv.base, rv.pat, 0);
      rv.exp_last  = model_addr(rv.base, rv.pat, rv.cnt - 1);
      run_job(rv);
    end

    // Reset while two reads are in flight.
    clear_logs();
    cur_pat = 0;
    bus.base_addr = 21'h000040; bus.count = 16'd10; bus.out_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("mid_rst_reads", 64'(addr_log.size()), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_rd_en", {bus.rd_en, bus.agu_step, bus.agu_clr, bus.done}, 4'b0);
    chk("mid_rst_rd_addr", bus.rd_addr, '0);
    chk("mid_rst_out", {bus.out_valid, bus.out_data}, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    acc = 1'b0;
    repeat (5) begin
      tick();
      acc = acc | bus.out_valid;
    end
    chk("post_rst_no_push", acc, 1'b0);
    run_job(vt[0]);

    // start coincident with done must be ignored.
    clear_logs();
    bus.base_addr = 21'h000500; bus.count = 16'd2; bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 100 && !bus.done; n++) tick();
    chk("seq_done_seen", bus.done, 1'b1);
    bus.base_addr = 21'h000777; bus.count = 16'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    acc = 1'b0;
    repeat (5) begin
      acc = acc | bus.agu_clr | bus.busy | bus.rd_en;
      tick();
    end
    chk("start_at_done_ignored", acc, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/agu_rdstream.md
Name: agu_rdstream

Overview:
- Read-stream engine that sits directly downstream of the address generation unit.
- Sequences a job of N word reads: drives the AGU's clear and step inputs, adds the AGU offset to a job base address, and issues reads to a fixed-latency RAM port.
- Returned words are buffered in an internal FIFO and presented on a valid/ready stream.
- A credit check guarantees the FIFO never overflows under backpressure.

Parameters:
- BWADDR, 21, address and offset width (matches the AGU).
- BWDATA, 32, RAM data word width.
- BWCOUNT, 16, job word-count width.
- RDLAT, 2, fixed RAM read latency in cycles (>=1).
- FIFODEPTH, 8, output FIFO entries; power of 2, >= RDLAT+1 so throughput is 1 word/cycle.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start pulse
- base_addr  in  BWADDR  job base address, sampled on start
- count  in  BWCOUNT  words in job, sampled on start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- agu_clr  out  1  clear to AGU
- agu_step  out  1  step to AGU
- agu_addr  in  BWADDR  AGU offset (registered in AGU)
- rd_en  out  1  RAM read strobe
- rd_addr  out  BWADDR  RAM read address
- rd_data  in  BWDATA  RAM read data, valid RDLAT cycles after rd_en
- out_data  out  BWDATA  stream data (FIFO head)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

Behaviour:
- Reset (rst_n low, async): FSM to IDLE. busy, done, agu_clr, agu_step, rd_en, out_valid = 0. rd_addr = 0. FIFO emptied, in-flight tracker cleared. Data returning after reset is discarded.
- FSM IDLE: start=1 latches base_addr/count (remaining <= count) and moves to CLR. start is ignored in any other state.
- FSM CLR (one cycle): agu_clr=1, busy=1. Next state is RUN if remaining != 0, else DRAIN.
- FSM RUN: issue = (fifo_cnt + inflight < FIFODEPTH) & (remaining != 0). When issue=1:
  - rd_en=1, agu_step=1, rd_addr = base + agu_addr (mod 2^BWADDR, carry dropped), remaining--.
  - rd_en, agu_step and rd_addr are combinational from current state/registers.
  - The AGU offset advances on the same edge, so consecutive issues use consecutive AGU addresses.
  - Move to DRAIN on the edge where remaining goes to 0.
- FSM DRAIN: no issues. When inflight==0 and FIFO empty: done=1 for one cycle (registered), busy drops the same cycle, state returns to IDLE.
- busy=1 in CLR, RUN and DRAIN, and deasserts in the cycle done pulses.
- In-flight tracker: RDLAT-deep valid shift register fed by rd_en. inflight = popcount (or an equivalent up/down counter). The word issued at edge t is written into the FIFO at edge t+RDLAT, so out_valid rises in cycle t+RDLAT+1 (earliest).
- FIFO: pop on out_valid & out_ready; out_data = head; push and pop in the same cycle are allowed at any fill level.
- Credit accounting: fifo_cnt and inflight are the values before the current edge. Pops freed this cycle become credit next cycle. The credit rule guarantees no overflow; overflow/underflow never occurs.
- out_valid and out_data change only on clock edges; out_data is held stable while out_valid & !out_ready.
- count=0: CLR, DRAIN, done 3 cycles after start, with zero reads.
- Address wrap: base + offset beyond 2^BWADDR-1 wraps modulo 2^BWADDR.
- start coincident with done: ignored (state is not yet IDLE).

Test Plan:
- base=0x100, count=4, AGU l=all 0 / j4=1, out_ready=1, RDLAT=2 -> rd_addr 0x100..0x103 on 4 consecutive cycles after CLR; out_data equals RAM contents in order; first out_valid 3 cycles after first rd_en; done once; busy low afterwards.
- count=20, out_ready=0 throughout, FIFODEPTH=8 -> exactly 8 rd_en pulses, then stall with out_valid=1. Release out_ready -> remaining 12 words arrive in order, none lost or duplicated; done after 20th pop.
- count=0 -> agu_clr pulse, no rd_en, done 3 cycles after start.
- base=0x1FFFFE, AGU j4=1, count=4 -> rd_addr 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
- Random out_ready (50%), count=100, multi-level AGU pattern (l4=3, j4=1, j3=16) -> output order matches the golden address sequence; FIFO never exceeds 8 entries.
- rst_n asserted mid-RUN with 2 reads in flight -> all outputs 0 immediately; returning rd_data not pushed; a new start after release runs cleanly.
